// File: rtl/pend_bit_sched_pkg.sv
// Shared sizing and FSM encoding for the pending-bit scheduler.
// No logic, no latency, no backpressure; constants and types only.
package pend_bit_sched_pkg;

  localparam int WIDTH = 32;
  localparam int POS_W = 5;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/pend_bit_sched_lead_one_enc.sv
// Leading-one encoder: index of the highest set bit of a 32-bit word, plus a zero flag.
// Purely combinational, no backpressure; the index is meaningless when zero is high.
module lead_one_enc (
  input  logic [31:0] in_vec,
  output logic [4:0]  pos,
  output logic        zero
);

  logic [15:0] x16;
  logic [7:0]  x8;
  logic [3:0]  x4;
  logic [1:0]  x2;
  logic        h4, h3, h2, h1;

  // Each stage keeps the upper half if it has any bit set; that choice is one index bit.
  always_comb begin
    h4   = |in_vec[31:16];
    x16  = h4 ? in_vec[31:16] : in_vec[15:0];
    h3   = |x16[15:8];
    x8   = h3 ? x16[15:8] : x16[7:0];
    h2   = |x8[7:4];
    x4   = h2 ? x8[7:4] : x8[3:0];
    h1   = |x4[3:2];
    x2   = h1 ? x4[3:2] : x4[1:0];
    pos  = {h4, h3, h2, h1, x2[1]};
    zero = ~|in_vec;
  end

endmodule

// File: rtl/pend_bit_sched.sv
// Fixed-priority scheduler: sticky pending word, highest index offered first.
// Set-to-offer in one cycle; an offer is held stable until gnt_rdy, then back-to-back.
module pend_bit_sched
  import pend_bit_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_vld,
  input  logic [WIDTH-1:0] set_mask,
  input  logic             clr_all,
  input  logic             en,
  output logic             gnt_vld,
  output logic [POS_W-1:0] gnt_pos,
  input  logic             gnt_rdy,
  output logic [WIDTH-1:0] pend,
  output logic             busy,
  output logic             ovf,
  output logic [CNT_W-1:0] acc_cnt
);

  state_t           state_q, state_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [POS_W-1:0] gnt_pos_q, gnt_pos_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

  logic             acc;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] set_vec;
  logic [POS_W-1:0] enc_pos;
  logic             enc_zero;
  logic             launch;

  // The encoder looks at next-cycle pending so a fresh set is offered one cycle later.
  lead_one_enc u_enc (
    .in_vec (pend_d),
    .pos    (enc_pos),
    .zero   (enc_zero)
  );

  always_comb begin
    acc     = gnt_vld_q & gnt_rdy;
    clr_vec = acc ? ({{(WIDTH-1){1'b0}}, 1'b1} << gnt_pos_q) : '0;
    set_vec = set_vld ? set_mask : '0;

    pend_d = clr_all ? '0 : ((pend_q & ~clr_vec) | set_vec);

    // A set landing on the bit just accepted is a re-arm, not an overflow.
    ovf_d = clr_all ? 1'b0 : (ovf_q | (|(set_vec & pend_q & ~clr_vec)));

    acc_cnt_d = acc_cnt_q + {{(CNT_W-1){1'b0}}, acc};
  end

  always_comb begin
    state_d   = state_q;
    gnt_vld_d = gnt_vld_q;
    gnt_pos_d = gnt_pos_q;
    launch    = ~clr_all & en & ~enc_zero;

    case (state_q)
      IDLE: begin
        gnt_vld_d = 1'b0;
        if (launch) begin
          gnt_pos_d = enc_pos;
          gnt_vld_d = 1'b1;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        gnt_vld_d = 1'b1;
        if (clr_all) begin
          gnt_vld_d = 1'b0;
          state_d   = IDLE;
        end else if (acc) begin
          if (launch) begin
            gnt_pos_d = enc_pos;
          end else begin
            gnt_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        gnt_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_vld_q <= 1'b0;
      gnt_pos_q <= '0;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      acc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_pos_q <= gnt_pos_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign gnt_vld = gnt_vld_q;
  assign gnt_pos = gnt_pos_q;
  assign pend    = pend_q;
  assign busy    = gnt_vld_q | (|pend_q);
  assign ovf     = ovf_q;
  assign acc_cnt = acc_cnt_q;

endmodule

// File: tb/tb_pend_bit_sched.sv
// Directed-vector bench for pend_bit_sched: table of single-cycle steps plus
// hand-written sequences for the 32-grant sweep, async reset and counter wrap.
module tb_pend_bit_sched;

  logic        clk;
  logic        rst_n;
  logic        set_vld;
  logic [31:0] set_mask;
  logic        clr_all;
  logic        en;
  logic        gnt_vld;
  logic [4:0]  gnt_pos;
  logic        gnt_rdy;
  logic [31:0] pend;
  logic        busy;
  logic        ovf;
  logic [7:0]  acc_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pend_bit_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_vld  (set_vld),
    .set_mask (set_mask),
    .clr_all  (clr_all),
    .en       (en),
    .gnt_vld  (gnt_vld),
    .gnt_pos  (gnt_pos),
    .gnt_rdy  (gnt_rdy),
    .pend     (pend),
    .busy     (busy),
    .ovf      (ovf),
    .acc_cnt  (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        set_vld;
    logic [31:0] set_mask;
    logic        clr_all;
    logic        en;
    logic        rdy;
    logic        vld;
    logic [4:0]  pos;
    logic [31:0] pend;
    logic        ovf;
    logic [7:0]  cnt;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  function automatic vec_t mk(logic sv, logic [31:0] sm, logic ca, logic e, logic r,
                              logic v, logic [4:0] p, logic [31:0] pd, logic o, logic [7:0] c);
    vec_t t;
    t.set_vld = sv; t.set_mask = sm; t.clr_all = ca; t.en = e; t.rdy = r;
    t.vld = v; t.pos = p; t.pend = pd; t.ovf = o; t.cnt = c;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_all(string tag, logic v, logic [4:0] p, logic [31:0] pd, logic o, logic [7:0] c);
    chk({tag, ".gnt_vld"}, {31'd0, gnt_vld}, {31'd0, v});
    if (v) chk({tag, ".gnt_pos"}, {27'd0, gnt_pos}, {27'd0, p});
    chk({tag, ".pend"},    pend, pd);
    chk({tag, ".ovf"},     {31'd0, ovf}, {31'd0, o});
    chk({tag, ".acc_cnt"}, {24'd0, acc_cnt}, {24'd0, c});
    chk({tag, ".busy"},    {31'd0, busy}, {31'd0, (v | (pd != 0))});
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(logic sv, logic [31:0] sm, logic ca, logic e, logic r);
    @(negedge clk);
    set_vld = sv; set_mask = sm; clr_all = ca; en = e; gnt_rdy = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_vld = 0; set_mask = '0; clr_all = 0; en = 0; gnt_rdy = 0;
    rst_n = 0;

    vt[0]  = mk(1, 32'h0000_0005, 0, 1, 1,  1,  2, 32'h0000_0005, 0, 0);
    vt[1]  = mk(0, 32'h0,         0, 1, 1,  1,  0, 32'h0000_0001, 0, 1);
    vt[2]  = mk(0, 32'h0,         0, 1, 1,  0,  0, 32'h0,         0, 2);
    vt[3]  = mk(1, 32'h0000_0010, 0, 1, 0,  1,  4, 32'h0000_0010, 0, 2);
    vt[4]  = mk(1, 32'h8000_0000, 0, 1, 0,  1,  4, 32'h8000_0010, 0, 2);
    vt[5]  = mk(0, 32'h0,         0, 1, 0,  1,  4, 32'h8000_0010, 0, 2);
    vt[6]  = mk(0, 32'h0,         0, 1, 1,  1, 31, 32'h8000_0000, 0, 3);
    vt[7]  = mk(0, 32'h0,         0, 1, 1,  0, 31, 32'h0,         0, 4);
    vt[8]  = mk(1, 32'h0000_0080, 0, 1, 0,  1,  7, 32'h0000_0080, 0, 4);
    vt[9]  = mk(1, 32'h0000_0080, 0, 1, 1,  1,  7, 32'h0000_0080, 0, 5);
    vt[10] = mk(1, 32'h0000_0008, 0, 1, 0,  1,  7, 32'h0000_0088, 0, 5);
    vt[11] = mk(1, 32'h0000_0008, 0, 1, 0,  1,  7, 32'h0000_0088, 1, 5);
    vt[12] = mk(0, 32'h0,         1, 1, 0,  0,  7, 32'h0,         0, 5);
    vt[13] = mk(1, 32'h0000_0300, 0, 1, 0,  1,  9, 32'h0000_0300, 0, 5);
    vt[14] = mk(0, 32'h0,         1, 1, 0,  0,  9, 32'h0,         0, 5);
    vt[15] = mk(1, 32'h0000_0300, 0, 1, 0,  1,  9, 32'h0000_0300, 0, 5);
    vt[16] = mk(0, 32'h0,         1, 1, 1,  0,  9, 32'h0,         0, 6);
    vt[17] = mk(0, 32'h0,         0, 1, 1,  0,  9, 32'h0,         0, 6);
    vt[18] = mk(1, 32'h0000_0001, 0, 1, 0,  1,  0, 32'h0000_0001, 0, 6);
    vt[19] = mk(0, 32'h0,         0, 0, 0,  1,  0, 32'h0000_0001, 0, 6);
    vt[20] = mk(1, 32'h0000_0002, 0, 0, 1,  0,  0, 32'h0000_0002, 0, 7);
    vt[21] = mk(0, 32'h0,         0, 0, 1,  0,  0, 32'h0000_0002, 0, 7);
    vt[22] = mk(0, 32'h0,         0, 1, 1,  1,  1, 32'h0000_0002, 0, 7);
    vt[23] = mk(0, 32'h0,         0, 1, 1,  0,  1, 32'h0,         0, 8);
    vt[24] = mk(1, 32'hFFFF_FFFF, 0, 0, 1,  0,  1, 32'hFFFF_FFFF, 0, 8);
    vt[25] = mk(0, 32'h0,         0, 0, 1,  0,  1, 32'hFFFF_FFFF, 0, 8);

    repeat (3) @(posedge clk);
    #1;
    chk("rst.gnt_pos", {27'd0, gnt_pos}, 32'd0);
    chk_all("rst", 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < NV; i++) begin
      step(vt[i].set_vld, vt[i].set_mask, vt[i].clr_all, vt[i].en, vt[i].rdy);
      chk_all($sformatf("vec%0d", i), vt[i].vld, vt[i].pos, vt[i].pend, vt[i].ovf, vt[i].cnt);
    end

    // Full word drains highest index first, one grant per cycle.
    for (int k = 0; k < 32; k++) begin
      step(0, 32'h0, 0, 1, 1);
      chk_all($sformatf("sweep%0d", k), 1, 5'(31 - k), 32'hFFFF_FFFF >> k, 0, 8'(8 + k));
    end
    step(0, 32'h0, 0, 1, 1);
    chk_all("sweep_end", 0, 0, 32'h0, 0, 40);

    // Async reset in the middle of an offer, away from any clock edge.
    step(1, 32'h0000_0010, 0, 1, 0);
    chk_all("pre_rst", 1, 4, 32'h0000_0010, 0, 40);
    #2;
    rst_n = 0;
    #1;
    chk("arst.gnt_pos", {27'd0, gnt_pos}, 32'd0);
    chk_all("arst", 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    set_vld = 0; gnt_rdy = 0;
    rst_n = 1;

    // Counter wrap: bit 0 re-armed every cycle, accepted every cycle.
    step(1, 32'h0000_0001, 0, 1, 1);
    chk_all("wrap_start", 1, 0, 32'h0000_0001, 0, 0);
    for (int k = 1; k <= 256; k++) begin
      step(1, 32'h0000_0001, 0, 1, 1);
      if (k == 128) chk_all("wrap128", 1, 0, 32'h0000_0001, 0, 128);
      if (k == 255) chk_all("wrap255", 1, 0, 32'h0000_0001, 0, 255);
      if (k == 256) chk_all("wrap256", 1, 0, 32'h0000_0001, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pend_bit_sched.md
Name: pend_bit_sched

Overview:
- Fixed-priority scheduler for a 32-entry pending-request word.
- Accumulates request bits into a sticky pending register.
- Uses a leading-one encoder to select the highest-index pending bit, and offers that index downstream on a valid/ready handshake.
- Clears each bit on acceptance; back-to-back grants issue one per cycle.
- Sits between event sources (interrupt/job flags) and a single shared consumer.

Parameters:
- WIDTH, 32, number of request bits; only 32 supported.
- POS_W, 5, width of grant index (log2 WIDTH).
- CNT_W, 8, width of the wrapping accept counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- set_vld  input  1  qualifies set_mask this cycle.
- set_mask  input  32  bits to mark pending.
- clr_all  input  1  synchronous flush of all state except counters.
- en  input  1  allows new grants to be launched.
- gnt_vld  output  1  grant offer valid.
- gnt_pos  output  5  index of granted bit; highest set index wins.
- gnt_rdy  input  1  consumer accepts offer.
- pend  output  32  current pending register.
- busy  output  1  gnt_vld OR (pend != 0).
- ovf  output  1  sticky: a set hit an already-pending bit.
- acc_cnt  output  8  accepted-grant count, wraps 255->0.

Behaviour:
- Reset (rst_n low, async): pend=0, gnt_vld=0, gnt_pos=0, ovf=0, acc_cnt=0, FSM=IDLE.
- Accept event: acc = gnt_vld & gnt_rdy. clr_vec = one-hot(gnt_pos) when acc, else 0.
- pend_next:
  - When clr_all: 0.
  - Otherwise: (pend & ~clr_vec) | (set_vld ? set_mask : 0).
  - A set on the bit being accepted in the same cycle re-arms it (set wins).
- ovf:
  - Set when set_vld & |(set_mask & pend & ~clr_vec).
  - Cleared only by clr_all or reset; clr_all wins if simultaneous.
- Encoder:
  - Combinational highest-set-index of pend_next.
  - Zero flag when pend_next==0; index is don't-care when zero.
- FSM, state IDLE:
  - gnt_vld=0.
  - When !clr_all & en & pend_next!=0: gnt_pos<=enc(pend_next), gnt_vld<=1, go OFFER.
  - Latency: set_vld at cycle N -> gnt_vld high at N+1.
- FSM, state OFFER:
  - gnt_vld=1; gnt_pos held stable until accepted.
  - No preemption by higher bits arriving later.
  - en low does not withdraw a current offer.
- FSM, on acc in OFFER:
  - acc_cnt<=acc_cnt+1.
  - When !clr_all & en & pend_next!=0: load gnt_pos<=enc(pend_next), stay OFFER (back-to-back, one grant per cycle).
  - Otherwise gnt_vld<=0, go IDLE.
- clr_all in any state: pend<=0, ovf<=0, gnt_vld<=0, FSM<=IDLE next edge. An acc in the same cycle still increments acc_cnt. acc_cnt is otherwise unaffected.
- gnt_rdy while gnt_vld=0 is ignored.
- The granted bit stays set in pend until accepted; it is visible on pend while offered.
- Reset asserted mid-offer: immediate drop of gnt_vld; no partial accept.
- Wrap: acc_cnt 255 + accept -> 0, no flag.

Decomposition:
- Shared package holds WIDTH, POS_W, CNT_W and the state enum {IDLE, OFFER}.
- One natural sub-module: lead_one_enc. It is a 32-bit combinational leading-one encoder producing the 5-bit index plus a zero flag, built as binary halving 16/8/4/2. It is instantiated on pend_next.
- Everything else (pend register, FSM, counters) stays in pend_bit_sched.

Test Plan:
- Basic: set_mask=0x0000_0005, en=1, gnt_rdy=1 -> gnt_pos=2 at cycle 1, then 0 at cycle 2, gnt_vld=0 at cycle 3, pend=0, acc_cnt=2.
- Stall and no preemption: pend=0x10, gnt_rdy=0, then set bit 31 -> gnt_pos stays 4 until gnt_rdy=1. Next offer is 31.
- Re-arm and overflow:
  - Offering 7, accept while set_mask=0x80 -> bit 7 stays pending and is re-offered; ovf stays 0.
  - set bit 3 twice while pending -> ovf=1.
- Enable gating: en=0 with pend=0xFFFF_FFFF -> gnt_vld stays 0. en=1 -> gnt_pos 31,30,...,0 on 32 consecutive cycles with gnt_rdy=1.
- Flush: clr_all during OFFER (pos 9, pend=0x0000_0300) -> next cycle gnt_vld=0, pend=0, ovf=0, acc_cnt unchanged.
- Counter wrap and async reset:
  - 256 accepts -> acc_cnt=0.
  - rst_n low mid-offer -> all outputs 0 without a clock edge.
